// File: rtl/rf_wb_sched_pkg.sv
// Shared constants for the register-file write-back scheduler.
// Requester indices select bits of the arbiter request/grant vectors.
package rf_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
endpackage

// File: rtl/rf_wb_sched_if.sv
// Bundle of producer, issue and register-file-port signals for rf_wb_sched.
// sb_err exists only when RF_SB_CHECK_EN is defined.
interface rf_wb_sched_if;
  import rf_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              stall;
  logic              RegWrite;
  logic [ADDR_W-1:0] Register_Destination;
  logic [DATA_W-1:0] wb_data;
  logic [NUM_REGS-1:0] busy_vec;
`ifdef RF_SB_CHECK_EN
  logic              sb_err;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd, rs1, rs2,
    input  alu_ready, mem_ready, stall, RegWrite, Register_Destination,
           wb_data, busy_vec
`ifdef RF_SB_CHECK_EN
    , input sb_err
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd, rs1, rs2,
    output alu_ready, mem_ready, stall, RegWrite, Register_Destination,
           wb_data, busy_vec
`ifdef RF_SB_CHECK_EN
    , output sb_err
`endif
  );
endinterface

// File: rtl/rf_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and flips to the other requester after every granted transfer.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt[REQ_MEM] = ptr_q;
      gnt[REQ_ALU] = ~ptr_q;
    end else begin
      gnt = req;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = gnt[REQ_ALU];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler: shares the register-file write port between ALU and
// load results and stalls issue on RAW/WAW hazards. Optional RF_SB_CHECK_EN adds sb_err.
module rf_wb_sched
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  rf_wb_sched_if.slave  bus
);
  logic [1:0]          req, gnt;
  logic                xfer;
  logic                issue_acc;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  assign req = {bus.mem_valid, bus.alu_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign bus.alu_ready = gnt[REQ_ALU] & ~rst;
  assign bus.mem_ready = gnt[REQ_MEM] & ~rst;
  assign xfer          = (|gnt) & ~rst;

  // Hazard check sees registered busy only, so a RAW read waits until after RegWrite.
  assign bus.stall = bus.issue_valid &
                     (busy_q[bus.rs1] | busy_q[bus.rs2] | busy_q[bus.issue_rd]);
  assign issue_acc = bus.issue_valid & ~bus.stall;

  always_comb begin
    we_d   = xfer;
    dst_d  = dst_q;
    data_d = data_q;
    if (xfer && gnt[REQ_MEM]) begin
      dst_d  = bus.mem_rd;
      data_d = bus.mem_data;
    end else if (xfer) begin
      dst_d  = bus.alu_rd;
      data_d = bus.alu_data;
    end
  end

  // Clear applied before set so an issue to the register being written keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (we_q)      busy_d[dst_q]        = 1'b0;
    if (issue_acc) busy_d[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      dst_q  <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      dst_q  <= dst_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign bus.RegWrite             = we_q;
  assign bus.Register_Destination = dst_q;
  assign bus.wb_data              = data_q;
  assign bus.busy_vec             = busy_q;

`ifdef RF_SB_CHECK_EN
  logic sb_err_q, sb_err_d;

  always_comb begin
    sb_err_d = sb_err_q;
    if (we_q && !busy_q[dst_q]) sb_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_err_q <= 1'b0;
    else     sb_err_q <= sb_err_d;
  end

  assign bus.sb_err = sb_err_q;
`endif
endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: vector table plus reset and sb_err sequences.
module tb_rf_wb_sched;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rf_wb_sched_if bus ();

  rf_wb_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] ard;
    logic [DATA_W-1:0] adat;
    logic              mv;
    logic [ADDR_W-1:0] mrd;
    logic [DATA_W-1:0] mdat;
    logic              iv;
    logic [ADDR_W-1:0] ird;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              e_ar;
    logic              e_mr;
    logic              e_st;
    logic              e_we;
    logic [ADDR_W-1:0] e_dst;
    logic [DATA_W-1:0] e_wd;
    logic [NUM_REGS-1:0] e_busy;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    bus.alu_valid = v.av; bus.alu_rd = v.ard; bus.alu_data = v.adat;
    bus.mem_valid = v.mv; bus.mem_rd = v.mrd; bus.mem_data = v.mdat;
    bus.issue_valid = v.iv; bus.issue_rd = v.ird; bus.rs1 = v.rs1; bus.rs2 = v.rs2;
    #1;
    check($sformatf("v%0d alu_ready", idx), 32'(bus.alu_ready), 32'(v.e_ar));
    check($sformatf("v%0d mem_ready", idx), 32'(bus.mem_ready), 32'(v.e_mr));
    check($sformatf("v%0d stall", idx), 32'(bus.stall), 32'(v.e_st));
    @(posedge clk);
    #1;
    check($sformatf("v%0d RegWrite", idx), 32'(bus.RegWrite), 32'(v.e_we));
    check($sformatf("v%0d Register_Destination", idx), 32'(bus.Register_Destination), 32'(v.e_dst));
    check($sformatf("v%0d wb_data", idx), 32'(bus.wb_data), 32'(v.e_wd));
    check($sformatf("v%0d busy_vec", idx), 32'(bus.busy_vec), 32'(v.e_busy));
    $display("[TB] vec %0d: ar=%0b mr=%0b stall=%0b we=%0b dst=%0d wd=%02h busy=%02h",
             idx, v.e_ar, v.e_mr, v.e_st, bus.RegWrite, bus.Register_Destination,
             bus.wb_data, bus.busy_vec);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // av ard adat  mv mrd mdat  iv ird rs1 rs2 | ar mr st | we dst wd busy
    vecs[0]  = '{1,7,8'hF0, 1,3,8'h55, 0,0,0,0, 1,0,0, 1,7,8'hF0,8'h00};
    vecs[1]  = '{1,1,8'h11, 1,3,8'h55, 0,0,0,0, 0,1,0, 1,3,8'h55,8'h00};
    vecs[2]  = '{1,1,8'h11, 1,2,8'h22, 0,0,0,0, 1,0,0, 1,1,8'h11,8'h00};
    vecs[3]  = '{0,0,8'h00, 1,2,8'h22, 0,0,0,0, 0,1,0, 1,2,8'h22,8'h00};
    vecs[4]  = '{0,0,8'h00, 1,4,8'h44, 0,0,0,0, 0,1,0, 1,4,8'h44,8'h00};
    vecs[5]  = '{1,5,8'h50, 1,6,8'h66, 0,0,0,0, 1,0,0, 1,5,8'h50,8'h00};
    vecs[6]  = '{0,0,8'h00, 0,0,8'h00, 0,0,0,0, 0,0,0, 0,5,8'h50,8'h00};
    vecs[7]  = '{0,0,8'h00, 0,0,8'h00, 1,0,1,2, 0,0,0, 0,5,8'h50,8'h01};
    vecs[8]  = '{1,0,8'hAA, 0,0,8'h00, 0,0,0,0, 1,0,0, 1,0,8'hAA,8'h01};
    vecs[9]  = '{0,0,8'h00, 0,0,8'h00, 0,0,0,0, 0,0,0, 0,0,8'hAA,8'h00};
    vecs[10] = '{0,0,8'h00, 0,0,8'h00, 1,2,0,0, 0,0,0, 0,0,8'hAA,8'h04};
    vecs[11] = '{1,2,8'hA2, 0,0,8'h00, 1,3,2,0, 1,0,1, 1,2,8'hA2,8'h04};
    vecs[12] = '{0,0,8'h00, 0,0,8'h00, 1,3,2,0, 0,0,1, 0,2,8'hA2,8'h00};
    vecs[13] = '{0,0,8'h00, 0,0,8'h00, 1,3,2,0, 0,0,0, 0,2,8'hA2,8'h08};
    vecs[14] = '{0,0,8'h00, 0,0,8'h00, 1,5,0,0, 0,0,0, 0,2,8'hA2,8'h28};
    vecs[15] = '{0,0,8'h00, 1,5,8'hB5, 1,1,0,5, 0,1,1, 1,5,8'hB5,8'h28};
    vecs[16] = '{0,0,8'h00, 0,0,8'h00, 1,1,0,5, 0,0,1, 0,5,8'hB5,8'h08};
    vecs[17] = '{0,0,8'h00, 0,0,8'h00, 1,1,0,5, 0,0,0, 0,5,8'hB5,8'h0A};
    vecs[18] = '{0,0,8'h00, 0,0,8'h00, 1,4,0,0, 0,0,0, 0,5,8'hB5,8'h1A};
    vecs[19] = '{1,4,8'hC4, 0,0,8'h00, 1,4,0,0, 1,0,1, 1,4,8'hC4,8'h1A};
    vecs[20] = '{0,0,8'h00, 0,0,8'h00, 1,4,0,0, 0,0,1, 0,4,8'hC4,8'h0A};
    vecs[21] = '{0,0,8'h00, 0,0,8'h00, 1,4,0,0, 0,0,0, 0,4,8'hC4,8'h1A};
    vecs[22] = '{1,4,8'hD4, 0,0,8'h00, 0,0,0,0, 1,0,0, 1,4,8'hD4,8'h1A};
    vecs[23] = '{0,0,8'h00, 0,0,8'h00, 0,0,0,0, 0,0,0, 0,4,8'hD4,8'h0A};
    vecs[24] = '{1,6,8'hE6, 0,0,8'h00, 0,0,0,0, 1,0,0, 1,6,8'hE6,8'h0A};
    vecs[25] = '{0,0,8'h00, 0,0,8'h00, 1,6,0,0, 0,0,0, 0,6,8'hE6,8'h4A};

    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset RegWrite", 32'(bus.RegWrite), 32'd0);
    check("reset Register_Destination", 32'(bus.Register_Destination), 32'd0);
    check("reset wb_data", 32'(bus.wb_data), 32'd0);
    check("reset busy_vec", 32'(bus.busy_vec), 32'd0);
`ifdef RF_SB_CHECK_EN
    check("reset sb_err", 32'(bus.sb_err), 32'd0);
`endif

    for (int i = 0; i < NV; i++) apply_vec(vecs[i], i);

    // Mid-stream reset with a write in flight and busy bits pending.
    @(negedge clk);
    drive_idle();
    bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 8'h77;
    @(posedge clk);
    #2;
    check("pre-rst RegWrite", 32'(bus.RegWrite), 32'd1);
    check("pre-rst busy_vec", 32'(bus.busy_vec), 32'h4A);
    rst = 1'b1;
    #1;
    check("rst RegWrite", 32'(bus.RegWrite), 32'd0);
    check("rst Register_Destination", 32'(bus.Register_Destination), 32'd0);
    check("rst wb_data", 32'(bus.wb_data), 32'd0);
    check("rst busy_vec", 32'(bus.busy_vec), 32'd0);
    check("rst alu_ready", 32'(bus.alu_ready), 32'd0);
    bus.mem_valid = 1; bus.mem_rd = 3; bus.mem_data = 8'h33;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst cyc%0d alu_ready", c), 32'(bus.alu_ready), 32'd0);
      check($sformatf("rst cyc%0d mem_ready", c), 32'(bus.mem_ready), 32'd0);
      check($sformatf("rst cyc%0d RegWrite", c), 32'(bus.RegWrite), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.alu_rd = 1; bus.alu_data = 8'h71;
    #1;
    check("post-rst alu_ready", 32'(bus.alu_ready), 32'd1);
    check("post-rst mem_ready", 32'(bus.mem_ready), 32'd0);
    @(posedge clk);
    #1;
    check("post-rst Register_Destination", 32'(bus.Register_Destination), 32'd1);
    check("post-rst wb_data", 32'(bus.wb_data), 32'h71);
    $display("[TB] mid-stream reset sequence done");

`ifdef RF_SB_CHECK_EN
    do_reset();
    #1;
    check("sb reset sb_err", 32'(bus.sb_err), 32'd0);
    drive_idle();
    bus.mem_valid = 1; bus.mem_rd = 6; bus.mem_data = 8'h66;
    @(posedge clk);
    #1;
    check("sb RegWrite", 32'(bus.RegWrite), 32'd1);
    check("sb Register_Destination", 32'(bus.Register_Destination), 32'd6);
    check("sb wb_data", 32'(bus.wb_data), 32'h66);
    check("sb sb_err during write", 32'(bus.sb_err), 32'd0);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check("sb sb_err set", 32'(bus.sb_err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("sb sb_err sticky", 32'(bus.sb_err), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("sb sb_err cleared", 32'(bus.sb_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] sb_err sequence done");
`endif

    drive_idle();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-back scheduler and hazard scoreboard for the 8-entry, 8-bit CPU register file.
- Shares the register file's single write port (RegWrite / Register_Destination / data) between two producers, the ALU and the memory-load path, using round-robin arbitration.
- Tracks registers with pending writes and raises a stall to the issue stage on RAW and WAW hazards.
- Sits between execute/memory stages and the register file write port.

Parameters:
DATA_W, 8, register data width
ADDR_W, 3, register address width
NUM_REGS, 8, register count (2**ADDR_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU result ready for write-back
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result ready for write-back
mem_ready  out  1  load result accepted this cycle
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
issue_valid  in  1  decode presents an instruction
issue_rd  in  ADDR_W  destination of the presented instruction
rs1  in  ADDR_W  first source operand
rs2  in  ADDR_W  second source operand
stall  out  1  instruction not accepted; hold issue
RegWrite  out  1  register file write enable
Register_Destination  out  ADDR_W  register file write address
wb_data  out  DATA_W  register file write data
busy_vec  out  NUM_REGS  pending-write bit per register

Behaviour:
- Reset (async, rst=1): RegWrite=0, Register_Destination=0, wb_data=0, busy_vec=0, RR pointer selects ALU. alu_ready and mem_ready are forced 0 while rst=1.
- Arbitration is combinational:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester the RR pointer selects.
  - Pointer moves to the other requester after any grant.
  - ready = grant. A transfer occurs when valid && ready. Requesters hold rd and data stable until ready.
- Write port is registered, with 1-cycle latency:
  - On a transfer at edge N, RegWrite=1 with the granted rd and data during cycle N+1.
  - With no transfer, RegWrite=0; address and data hold their last values.
  - Back-to-back transfers give continuous RegWrite=1.
- Scoreboard:
  - Accepted issue (issue_valid && !stall) sets busy[issue_rd] at the edge.
  - busy[Register_Destination] clears at the edge ending a cycle with RegWrite=1, the same edge the register file captures the data.
  - Set and clear on the same register in the same edge: set wins.
  - Write-back to a non-busy register still writes; busy is unchanged.
- Stall is combinational: stall = issue_valid && (busy[rs1] || busy[rs2] || busy[issue_rd]).
  - Uses registered busy only; there is no same-cycle bypass.
  - A stalled issue changes no state.
  - The earliest non-stalled RAW read is the cycle after the RegWrite cycle.
- Register 0 is an ordinary writable register.
- Reset mid-operation: pending busy bits and any in-flight registered write are discarded. RegWrite drops to 0 immediately.

Optional Feature:
- Macro RF_SB_CHECK_EN.
- Defined:
  - Adds output sb_err (1 bit), reset 0.
  - Sticky set when RegWrite=1 targets a register whose busy bit is 0.
  - Cleared only by rst.
- Undefined: no sb_err port and no check logic; all other behaviour identical.

Decomposition:
- Package rf_pkg: DATA_W, ADDR_W, NUM_REGS constants; requester index constants REQ_ALU=0, REQ_MEM=1.
- One sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: clk, rst, req[1:0], advance.
  - Output: one-hot gnt[1:0].
  - Owns the pointer.
- Scoreboard and write-port registers stay in rf_wb_sched.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream -> busy_vec=8'h00, RegWrite=0, Register_Destination=0, wb_data=0, both readies 0 during rst.
- Single write-back:
  - issue_rd=0 accepted -> busy_vec=8'h01.
  - alu_valid, alu_rd=0, alu_data=8'hAA -> alu_ready=1, next cycle RegWrite=1/Register_Destination=0/wb_data=8'hAA, busy_vec=8'h00 after.
- Contention:
  - alu_valid (rd=7, 8'hF0) and mem_valid (rd=3, 8'h55) together from reset -> ALU granted first.
  - Write r7=F0, then r3=55 on consecutive cycles.
  - Repeat with both valid -> grants alternate.
- RAW stall:
  - issue_rd=2 accepted, then issue with rs1=2 -> stall=1 until the cycle after RegWrite to r2.
  - Same for rs2 with r5.
- WAW stall: busy[4]=1 and issue_rd=4 -> stall=1; after write-back to r4 completes, issue accepted and busy[4] set again.
- RF_SB_CHECK_EN build: mem write-back to non-busy r6 -> register written, sb_err=1 and stays 1 until rst.
